// File: rtl/fft_out_buffer.sv
// FFT output buffer: packs one 1024-sample frame into 128 x 512-bit lines and drains them to the memory controller.
// Optional FFT_OUT_BUFFER_BITREV_EN stores samples at the bit-reversed arrival index (DIT output to natural order).
module fft_out_buffer (
  input  logic         clk,
  input  logic         rst,
  input  logic         loadOutBuffer,
  input  logic [63:0]  sampleIn,
  input  logic         accelWrBlkDone,
  output logic [511:0] mcDataOut,
  output logic         mcDataOutValid,
  output logic         outFifoReady,
  output logic         outFifoEmpty,
  output logic         ovfErr
);

  localparam int DATA_W = 64;
  localparam int LINES  = 128;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t       state, stateNext;
  logic [9:0]   wrCnt;
  logic [9:0]   wrIdx;
  logic [6:0]   rdPtr;
  logic         accept;
  logic         pop;
  logic [511:0] lineMem [LINES];

`ifdef FFT_OUT_BUFFER_BITREV_EN
  function automatic logic [9:0] bitRev10(input logic [9:0] v);
    logic [9:0] r;
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
    return r;
  endfunction

  assign wrIdx = bitRev10(wrCnt);
`else
  assign wrIdx = wrCnt;
`endif

  always_comb begin
    stateNext = state;
    accept    = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (loadOutBuffer) begin
          accept    = 1'b1;
          stateNext = FILL;
        end
      end
      FILL: begin
        if (loadOutBuffer) begin
          accept = 1'b1;
          if (wrCnt == 10'd1023) stateNext = DRAIN;
        end
      end
      DRAIN: begin
        if (accelWrBlkDone) begin
          pop = 1'b1;
          if (rdPtr == 7'd127) stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      wrCnt  <= '0;
      rdPtr  <= '0;
      ovfErr <= 1'b0;
    end else begin
      state <= stateNext;
      if (accept) wrCnt <= wrCnt + 10'd1;
      // rdPtr wraps 127 -> 0 on the final pop, leaving it ready for the next frame
      if (pop) rdPtr <= rdPtr + 7'd1;
      if ((state == DRAIN) && loadOutBuffer) ovfErr <= 1'b1;
    end
  end

  // Storage is deliberately unreset; a restarted frame simply overwrites it.
  always_ff @(posedge clk) begin
    if (accept) lineMem[wrIdx[9:3]][{wrIdx[2:0], 6'b0} +: DATA_W] <= sampleIn;
  end

  assign mcDataOutValid = (state == DRAIN);
  assign outFifoReady   = (state == DRAIN);
  assign outFifoEmpty   = (state == IDLE);
  assign mcDataOut      = mcDataOutValid ? lineMem[rdPtr] : '0;

endmodule

// File: tb/tb_fft_out_buffer.sv
// Directed bench for fft_out_buffer: table of line/lane expectations plus hand-written fill, drain, overflow and reset sequences.
module tb_fft_out_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         loadOutBuffer = 1'b0;
  logic [63:0]  sampleIn = '0;
  logic         accelWrBlkDone = 1'b0;
  logic [511:0] mcDataOut;
  logic         mcDataOutValid;
  logic         outFifoReady;
  logic         outFifoEmpty;
  logic         ovfErr;

  int checks = 0;
  int errors = 0;

  fft_out_buffer dut (
    .clk(clk),
    .rst(rst),
    .loadOutBuffer(loadOutBuffer),
    .sampleIn(sampleIn),
    .accelWrBlkDone(accelWrBlkDone),
    .mcDataOut(mcDataOut),
    .mcDataOutValid(mcDataOutValid),
    .outFifoReady(outFifoReady),
    .outFifoEmpty(outFifoEmpty),
    .ovfErr(ovfErr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          line;
    int          lane;
    logic [31:0] expReal;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] arrivalFor(input int n);
    logic [9:0] v;
    logic [9:0] r;
    v = n[9:0];
`ifdef FFT_OUT_BUFFER_BITREV_EN
    for (int i = 0; i < 10; i++) r[i] = v[9-i];
`else
    r = v;
`endif
    return {22'd0, r};
  endfunction

  function automatic logic [511:0] expLine(input int line);
    logic [511:0] l;
    logic [31:0]  a;
    for (int lane = 0; lane < 8; lane++) begin
      a = arrivalFor(line * 8 + lane);
      l[lane*64 +: 64] = {a, ~a};
    end
    return l;
  endfunction

  task automatic checkOutputsReset(input string tag);
    check({tag, "_empty"}, 512'(outFifoEmpty), 512'd1);
    check({tag, "_ready"}, 512'(outFifoReady), 512'd0);
    check({tag, "_valid"}, 512'(mcDataOutValid), 512'd0);
    check({tag, "_data"}, mcDataOut, '0);
    check({tag, "_ovf"}, 512'(ovfErr), 512'd0);
  endtask

  // Sends 1024 samples {k,~k}; optional idle gap after every third sample; done pulses are ignored in FILL.
  task automatic fillFrame(input bit gaps);
    logic [31:0] kv;
    for (int k = 0; k < 1024; k++) begin
      if (k == 1023) check("preLastNotDrain", 512'(mcDataOutValid), 512'd0);
      kv = k;
      loadOutBuffer  = 1'b1;
      sampleIn       = {kv, ~kv};
      accelWrBlkDone = (k == 5) || (k == 600);
      tick();
      loadOutBuffer  = 1'b0;
      accelWrBlkDone = 1'b0;
      if (gaps && (k % 3 == 1)) tick();
    end
  endtask

  task automatic pop();
    accelWrBlkDone = 1'b1;
    tick();
    accelWrBlkDone = 1'b0;
  endtask

  initial begin
    int curLine;
`ifdef FFT_OUT_BUFFER_BITREV_EN
    vecs[0] = '{0, 0, 32'd0};
    vecs[1] = '{0, 1, 32'd512};
    vecs[2] = '{0, 7, 32'd896};
    vecs[3] = '{1, 0, 32'd64};
    vecs[4] = '{63, 5, 32'd766};
    vecs[5] = '{127, 7, 32'd1023};
`else
    vecs[0] = '{0, 0, 32'd0};
    vecs[1] = '{0, 1, 32'd1};
    vecs[2] = '{0, 7, 32'd7};
    vecs[3] = '{1, 0, 32'd8};
    vecs[4] = '{63, 5, 32'd509};
    vecs[5] = '{127, 7, 32'd1023};
`endif

    // Mid-cycle asynchronous reset
    tick();
    #2 rst = 1'b0;
    #1 checkOutputsReset("rst0");
    tick();
    #2 rst = 1'b1;
    tick();

    // Done in IDLE ignored, contiguous frame, table-driven line checks
    pop();
    check("idleEmpty", 512'(outFifoEmpty), 512'd1);
    fillFrame(1'b0);
    check("drainValid", 512'(mcDataOutValid), 512'd1);
    check("drainReady", 512'(outFifoReady), 512'd1);
    check("drainEmpty", 512'(outFifoEmpty), 512'd0);
    curLine = 0;
    for (int i = 0; i < 6; i++) begin
      while (curLine < vecs[i].line) begin
        pop();
        curLine++;
      end
      check($sformatf("vec%0d_l%0d_s%0d", i, vecs[i].line, vecs[i].lane),
            512'(mcDataOut[vecs[i].lane*64 +: 64]),
            512'({vecs[i].expReal, ~vecs[i].expReal}));
    end
    pop();
    check("endIdleEmpty", 512'(outFifoEmpty), 512'd1);
    check("endIdleValid", 512'(mcDataOutValid), 512'd0);
    check("endIdleData", mcDataOut, '0);

    // Gapped fill, overflow attempt, then drain every other cycle
    fillFrame(1'b1);
    check("gapDrainValid", 512'(mcDataOutValid), 512'd1);
    loadOutBuffer = 1'b1;
    sampleIn      = '1;
    tick();
    loadOutBuffer = 1'b0;
    check("ovfSet", 512'(ovfErr), 512'd1);
    for (int l = 0; l < 128; l++) begin
      check($sformatf("gapLine%0d", l), mcDataOut, expLine(l));
      tick();
      check($sformatf("holdLine%0d", l), mcDataOut, expLine(l));
      pop();
    end
    check("gapEndEmpty", 512'(outFifoEmpty), 512'd1);
    check("gapEndValid", 512'(mcDataOutValid), 512'd0);
    check("ovfStickyIdle", 512'(ovfErr), 512'd1);

    // ovfErr persists across the next frame; reset mid-DRAIN clears everything
    fillFrame(1'b0);
    check("ovfStickyDrain", 512'(ovfErr), 512'd1);
    check("frame3Line0", mcDataOut, expLine(0));
    for (int i = 0; i < 5; i++) pop();
    check("frame3Line5", mcDataOut, expLine(5));
    #3 rst = 1'b0;
    #1 checkOutputsReset("rstDrain");
    tick();
    rst = 1'b1;
    tick();

    // Reset mid-FILL discards the partial frame; next frame needs a full 1024 samples
    for (int k = 0; k < 100; k++) begin
      loadOutBuffer = 1'b1;
      sampleIn      = '0;
      tick();
    end
    loadOutBuffer = 1'b0;
    check("midFillNotEmpty", 512'(outFifoEmpty), 512'd0);
    #2 rst = 1'b0;
    #1 checkOutputsReset("rstFill");
    tick();
    rst = 1'b1;
    tick();
    fillFrame(1'b0);
    check("afterRstDrainValid", 512'(mcDataOutValid), 512'd1);
    check("afterRstLine0", mcDataOut, expLine(0));
    pop();
    check("afterRstLine1", mcDataOut, expLine(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
